rf_alu_sequencer: RTL and testbench
===================================

// Module: rf_alu_sequencer
// PURPOSE
//  Initiator for the 8x8 register file. Accepts one ALU command per valid/ready handshake.
//  Drives the read addresses RX/RY and captures busX/busY into operand registers.
//  Computes the result, then drives WEN/RW/busW to write it back.
//  Fully serialized, 4 cycles per command; sits between the command source and register_file.
// PARAMETERS
//  DW  8  data width (matches register file busW/busX/busY)
//  AW  3  register address width (2**AW registers)
// PORTS
//  Clk        in   1   clock; all state changes on posedge
//  Rst        in   1   synchronous, active-high reset
//  cmd_valid  in   1   command present
//  cmd_ready  out  1   sequencer can accept (high only in IDLE)
//  cmd_op     in   3   0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 MOV
//  cmd_rd     in   AW  destination register
//  cmd_rs     in   AW  source A register -> RX
//  cmd_rt     in   AW  source B register -> RY
//  RX, RY     out  AW  register file read addresses
//  busX,busY  in   DW  register file read data (combinational from RX/RY)
//  WEN        out  1   register file write enable
//  RW         out  AW  register file write address
//  busW       out  DW  register file write data
//  done       out  1   one-cycle pulse in the write-back cycle
//  result     out  DW  last computed result; held until next EXEC
// BEHAVIOUR
//  Reset: state=IDLE; cmd_ready=1; WEN=0; done=0; RX=RY=RW=0; busW=0; result=0; operand regs=0.
//  FSM IDLE->READ->EXEC->WB->IDLE, one cycle per state. Outputs decode from registers only, never from cmd_*.
//  IDLE: on cmd_valid&&cmd_ready, latch op/rd/rs/rt and go to READ; otherwise stay.
//  READ: RX=rs, RY=rt; edge captures opA=busX, opB=busY; go to EXEC.
//  EXEC: edge computes result from opA/opB; go to WB.
//  WB: RW=rd, busW=result, done=1, WEN=(rd!=0). Register file writes on this edge; go to IDLE.
//  Write to r0: WEN stays low but done still pulses. The register file hard-wires r0=0 regardless.
//  Latency: accept edge E0, capture E1, compute E2, write E3; earliest next accept E4.
//  Back-to-back dependent commands are hazard-free: the write at E3 is visible to the READ after E4.
//  Arithmetic: DW-bit modulo wrap for ADD/SUB. SLL/SRL shift opA by opB[2:0], zero-fill. MOV result=opA.
//  cmd_* changes outside the accept edge are ignored.
//  Rst mid-operation (any state): next edge returns to IDLE with all outputs at reset values.
//   WEN is low from that cycle, so no partial write occurs. The latched command is discarded.
//  Rst has priority over a simultaneous cmd_valid; the command is not accepted.
// CONFIGURATION
//  RF_SAT_EN defined: ADD/SUB saturate unsigned (overflow->{DW{1'b1}}, underflow->0).
//  RF_SAT_EN undefined: ADD/SUB wrap modulo 2**DW. All other ops are identical in both builds.
// STRUCTURE
//  Package rf_seq_pkg: op encodings (OP_ADD..OP_MOV), FSM state typedef/localparams, DW/AW defaults.
//  One sub-module, rf_seq_alu: combinational (op, opA, opB) -> result. It contains the RF_SAT_EN logic.
//  The top holds the FSM, command latch, operand and result registers.
// TESTING
//  Bench instantiates register_file plus rf_alu_sequencer; preload via MOV chains from a seeded r1.
//  1. Reset, then cmd ADD rd=3 rs=1 rt=2 with r1=8'h05, r2=8'h0A -> WEN at E3, RW=3, busW=8'h0F, done 1 cycle.
//  2. ADD r1=8'hF0, r2=8'h20 -> 8'h10 wrap; with RF_SAT_EN -> 8'hFF. SUB 8'h10-8'h20 -> 8'hF0 / 8'h00.
//  3. Cmd rd=0 -> done pulses, WEN never high, r0 reads 8'h00 afterwards.
//  4. Back-to-back: ADD rd=4 then XOR rd=5 rs=4 -> second uses new r4; cmd_ready low for 3 cycles each.
//  5. Rst asserted in EXEC -> no WEN, cmd_ready=1 next cycle, destination register unchanged.
//  6. SLL opA=8'h81 opB=8'h09 -> shift 1 -> 8'h02; SRL -> 8'h40; MOV -> 8'h81.

Source files
------------

// File: rtl/rf_seq_pkg.sv
// Shared encodings for the register-file ALU sequencer.
// Build with RF_SAT_EN defined for saturating unsigned ADD/SUB.
package rf_seq_pkg;

    localparam int RF_DW = 8;
    localparam int RF_AW = 3;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SLL = 3'd5,
        OP_SRL = 3'd6,
        OP_MOV = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_e;

endpackage

// File: rtl/rf_seq_alu.sv
// Combinational ALU for the sequencer.
// RF_SAT_EN selects unsigned saturation for ADD/SUB.
module rf_seq_alu
    import rf_seq_pkg::*;
#(
    parameter int DW = RF_DW
) (
    input  logic [2:0]    i_op,
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    output logic [DW-1:0] o_y
);

    logic [DW-1:0] w_add;
    logic [DW-1:0] w_sub;

`ifdef RF_SAT_EN
    logic [DW:0] w_sum;
    logic [DW:0] w_dif;

    // Top bit is carry-out for the sum and borrow for the difference.
    assign w_sum = {1'b0, i_a} + {1'b0, i_b};
    assign w_dif = {1'b0, i_a} - {1'b0, i_b};
    assign w_add = w_sum[DW] ? {DW{1'b1}} : w_sum[DW-1:0];
    assign w_sub = w_dif[DW] ? {DW{1'b0}} : w_dif[DW-1:0];
`else
    assign w_add = i_a + i_b;
    assign w_sub = i_a - i_b;
`endif

    always_comb begin
        o_y = '0;
        unique case (i_op)
            OP_ADD: o_y = w_add;
            OP_SUB: o_y = w_sub;
            OP_AND: o_y = i_a & i_b;
            OP_OR:  o_y = i_a | i_b;
            OP_XOR: o_y = i_a ^ i_b;
            OP_SLL: o_y = i_a << i_b[2:0];
            OP_SRL: o_y = i_a >> i_b[2:0];
            OP_MOV: o_y = i_a;
        endcase
    end

endmodule

// File: rtl/rf_alu_sequencer.sv
// Serialized read/execute/write-back initiator for the 8x8 register file.
// RF_SAT_EN (see rf_seq_alu) switches ADD/SUB to unsigned saturation.
module rf_alu_sequencer
    import rf_seq_pkg::*;
#(
    parameter int DW = RF_DW,
    parameter int AW = RF_AW
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [AW-1:0] cmd_rd,
    input  logic [AW-1:0] cmd_rs,
    input  logic [AW-1:0] cmd_rt,
    output logic [AW-1:0] RX,
    output logic [AW-1:0] RY,
    input  logic [DW-1:0] busX,
    input  logic [DW-1:0] busY,
    output logic          WEN,
    output logic [AW-1:0] RW,
    output logic [DW-1:0] busW,
    output logic          done,
    output logic [DW-1:0] result
);

    state_e        r_state;
    logic [2:0]    r_op;
    logic [AW-1:0] r_rd;
    logic [DW-1:0] r_opa;
    logic [DW-1:0] r_opb;
    logic [DW-1:0] w_alu;

    rf_seq_alu #(.DW(DW)) u_alu (
        .i_op (r_op),
        .i_a  (r_opa),
        .i_b  (r_opb),
        .o_y  (w_alu)
    );

    // RX/RY are loaded on the accept edge so busX/busY settle during READ.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state   <= ST_IDLE;
            r_op      <= '0;
            r_rd      <= '0;
            r_opa     <= '0;
            r_opb     <= '0;
            cmd_ready <= 1'b1;
            RX        <= '0;
            RY        <= '0;
            WEN       <= 1'b0;
            RW        <= '0;
            busW      <= '0;
            done      <= 1'b0;
            result    <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        r_op      <= cmd_op;
                        r_rd      <= cmd_rd;
                        RX        <= cmd_rs;
                        RY        <= cmd_rt;
                        cmd_ready <= 1'b0;
                        r_state   <= ST_READ;
                    end
                end
                ST_READ: begin
                    r_opa   <= busX;
                    r_opb   <= busY;
                    r_state <= ST_EXEC;
                end
                ST_EXEC: begin
                    result  <= w_alu;
                    busW    <= w_alu;
                    RW      <= r_rd;
                    WEN     <= (r_rd != '0);
                    done    <= 1'b1;
                    r_state <= ST_WB;
                end
                ST_WB: begin
                    WEN       <= 1'b0;
                    done      <= 1'b0;
                    cmd_ready <= 1'b1;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rf_alu_sequencer.sv
// Directed bench: sequencer against a behavioural 8x8 register file.
// Define RF_SAT_EN for both bench and RTL to check the saturating build.
module tb_rf_alu_sequencer;
    import rf_seq_pkg::*;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = '0;
    logic [2:0] cmd_rd = '0;
    logic [2:0] cmd_rs = '0;
    logic [2:0] cmd_rt = '0;
    logic [2:0] RX, RY, RW;
    logic [7:0] busX, busY, busW, result;
    logic       WEN, done;

    logic [7:0] rf [8];
    int n_pass = 0;
    int n_total = 0;

    always #5 Clk = ~Clk;

    // Register file: r0 hard-wired to zero, write on posedge when WEN.
    assign busX = (RX == 3'd0) ? 8'h00 : rf[RX];
    assign busY = (RY == 3'd0) ? 8'h00 : rf[RY];
    always @(posedge Clk) if (WEN) rf[RW] = busW;

    rf_alu_sequencer dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_rd    (cmd_rd),
        .cmd_rs    (cmd_rs),
        .cmd_rt    (cmd_rt),
        .RX        (RX),
        .RY        (RY),
        .busX      (busX),
        .busY      (busY),
        .WEN       (WEN),
        .RW        (RW),
        .busW      (busW),
        .done      (done),
        .result    (result)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [7:0] rf_rd(input logic [2:0] a);
        return (a == 3'd0) ? 8'h00 : rf[a];
    endfunction

    // Called at a negedge with the sequencer idle; returns at the
    // negedge after the write-back edge, so calls chain back-to-back.
    task automatic do_cmd(input string tag, input op_e op,
                          input logic [2:0] rd, input logic [2:0] rs,
                          input logic [2:0] rt, input logic [7:0] exp);
        check({tag, " ready@accept"}, cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_rd = rd;
        cmd_rs = rs;
        cmd_rt = rt;
        @(posedge Clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op = 3'($urandom);
        cmd_rd = 3'($urandom);
        cmd_rs = 3'($urandom);
        cmd_rt = 3'($urandom);
        @(negedge Clk);
        check({tag, " ready READ"}, cmd_ready, 0);
        check({tag, " RX"}, RX, rs);
        check({tag, " WEN READ"}, WEN, 0);
        @(negedge Clk);
        check({tag, " ready EXEC"}, cmd_ready, 0);
        check({tag, " done EXEC"}, done, 0);
        @(negedge Clk);
        check({tag, " ready WB"}, cmd_ready, 0);
        check({tag, " done WB"}, done, 1);
        check({tag, " WEN WB"}, WEN, (rd != 3'd0));
        check({tag, " RW"}, RW, rd);
        check({tag, " busW"}, busW, exp);
        @(negedge Clk);
        check({tag, " ready IDLE"}, cmd_ready, 1);
        check({tag, " done IDLE"}, done, 0);
        check({tag, " WEN IDLE"}, WEN, 0);
        check({tag, " result"}, result, exp);
        if (rd != 3'd0) check({tag, " rf[rd]"}, rf[rd], exp);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) rf[i] = 8'h00;

        repeat (2) @(negedge Clk);
        check("rst ready", cmd_ready, 1);
        check("rst WEN", WEN, 0);
        check("rst done", done, 0);
        check("rst RX", RX, 0);
        check("rst RY", RY, 0);
        check("rst RW", RW, 0);
        check("rst busW", busW, 0);
        check("rst result", result, 0);
        Rst = 1'b0;
        @(negedge Clk);

        rf[1] = 8'h05; rf[2] = 8'h0A;
        do_cmd("add", OP_ADD, 3'd3, 3'd1, 3'd2, 8'h0F);

        rf[1] = 8'hF0; rf[2] = 8'h20;
`ifdef RF_SAT_EN
        do_cmd("add ovf", OP_ADD, 3'd3, 3'd1, 3'd2, 8'hFF);
`else
        do_cmd("add ovf", OP_ADD, 3'd3, 3'd1, 3'd2, 8'h10);
`endif
        rf[1] = 8'h10;
`ifdef RF_SAT_EN
        do_cmd("sub udf", OP_SUB, 3'd3, 3'd1, 3'd2, 8'h00);
`else
        do_cmd("sub udf", OP_SUB, 3'd3, 3'd1, 3'd2, 8'hF0);
`endif

        rf[1] = 8'h55;
        do_cmd("mov r0", OP_MOV, 3'd0, 3'd1, 3'd2, 8'h55);
        do_cmd("read r0", OP_MOV, 3'd1, 3'd0, 3'd2, 8'h00);

        rf[1] = 8'h03; rf[2] = 8'h04;
        do_cmd("b2b add", OP_ADD, 3'd4, 3'd1, 3'd2, 8'h07);
        do_cmd("b2b xor", OP_XOR, 3'd5, 3'd4, 3'd2, 8'h03);
        do_cmd("and", OP_AND, 3'd6, 3'd5, 3'd4, 8'h03);
        do_cmd("or", OP_OR, 3'd6, 3'd2, 3'd5, 8'h07);

        // Reset during EXEC, with cmd_valid held high through the reset.
        rf[1] = 8'h01; rf[2] = 8'h02; rf[6] = 8'hAA;
        cmd_valid = 1'b1;
        cmd_op = OP_ADD;
        cmd_rd = 3'd6; cmd_rs = 3'd1; cmd_rt = 3'd2;
        @(negedge Clk);
        @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        check("rstx ready", cmd_ready, 1);
        check("rstx WEN", WEN, 0);
        check("rstx done", done, 0);
        check("rstx result", result, 0);
        @(negedge Clk);
        Rst = 1'b0;
        cmd_valid = 1'b0;
        @(negedge Clk);
        check("rstx no accept", cmd_ready, 1);
        check("rstx WEN2", WEN, 0);
        check("rstx r6", rf_rd(3'd6), 8'hAA);

        rf[1] = 8'h81; rf[2] = 8'h09;
        do_cmd("mov chain", OP_MOV, 3'd6, 3'd1, 3'd0, 8'h81);
        do_cmd("sll", OP_SLL, 3'd3, 3'd6, 3'd2, 8'h02);
        do_cmd("srl", OP_SRL, 3'd3, 3'd6, 3'd2, 8'h40);
        do_cmd("mov", OP_MOV, 3'd7, 3'd6, 3'd2, 8'h81);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
